wbu_pipe: RTL and testbench
===========================

Name: wbu_pipe

Overview:
- Registered, parametrised write-back stage for the rvcpu core. Sits between the MEM stage and the register file.
- Accepts one retiring instruction per handshake from MEM. For loads, waits for the memory read response when it arrives later than the instruction.
- Extracts and sign- or zero-extends load data by access type and byte offset, then drives the register-file write port.
- Also produces a commit strobe and a retire counter for difftest and performance use.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- CNT_W, 32, width of the retire counter.
- OFF_W, $clog2(XLEN/8), width of the byte-offset input (derived; do not override).

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset; one clock; reset is synchronous and active-low
- i_valid  input  1  MEM stage presents an instruction
- o_ready  output  1  stage can accept an instruction
- i_flush  input  1  discard the in-flight or offered instruction
- i_rd_data  input  XLEN  ALU/CSR result
- i_rd_addr  input  5  destination register
- i_rd_wen  input  1  instruction writes rd
- i_mem_read  input  1  instruction is a load
- i_load_type  input  3  funct3 of the load
- i_addr_lo  input  OFF_W  low byte-address bits of the load
- i_mem_rvalid  input  1  memory read data valid
- i_mem_rdata  input  XLEN  memory read data (aligned XLEN word)
- o_rd_wen  output  1  register-file write enable
- o_rd_addr  output  5  register-file write address
- o_rd_wdata  output  XLEN  register-file write data
- o_commit  output  1  one instruction retired this cycle
- o_commit_cnt  output  CNT_W  retired-instruction count

Behaviour:

Reset and handshake:
- Reset: state=IDLE; o_rd_wen=0, o_rd_addr=0, o_rd_wdata=0, o_commit=0, o_commit_cnt=0. Any in-flight instruction is dropped.
- All outputs are registered. o_ready is combinational and equals (state==IDLE).
- Accept condition: i_valid && o_ready && !i_flush. Fields are captured only on accept.

States and transitions:
- IDLE, non-load accept (i_mem_read=0): write result in the next cycle. Latency is 1. Stay in IDLE, so throughput is 1 per cycle.
- IDLE, load accept with i_mem_rvalid=1 in the same cycle: write extracted data in the next cycle. Stay in IDLE.
- IDLE, load accept with i_mem_rvalid=0: go to WAIT, holding the captured fields.
- WAIT: o_ready=0. When i_mem_rvalid=1, write extracted data in the next cycle and return to IDLE.
- i_mem_rvalid in IDLE without a load accept is ignored.
- i_flush: in IDLE, the offered instruction is not accepted and nothing is written. In WAIT, abandon the load, return to IDLE, no write, no commit.
- If i_flush and i_mem_rvalid are high in the same WAIT cycle, the flush wins.

Retire and counter:
- Retire cycle: o_commit=1; o_rd_addr=captured rd; o_rd_wdata=result.
- o_rd_wen = captured wen && rd!=0, so x0 is never written but a commit is still signalled.
- In non-retire cycles: o_commit=0, o_rd_wen=0; o_rd_addr and o_rd_wdata hold their last values.
- o_commit_cnt increments by 1 in the cycle o_commit rises. It wraps from 2^CNT_W-1 to 0.

Load extraction:
- Shift: sh = i_mem_rdata >> (8*addr_lo).
- Type mapping:
  - 000 LB: sign-extend sh[7:0]
  - 001 LH: sign-extend sh[15:0]
  - 010 LW: sign-extend sh[31:0]
  - 011 LD: sh
  - 100 LBU: zero-extend sh[7:0]
  - 101 LHU: zero-extend sh[15:0]
  - 110 LWU: zero-extend sh[31:0]
  - 111: sh
- XLEN=32: LD, LWU and 111 all yield sh[31:0].
- Misaligned accesses are not supported. Bytes shifted in from beyond XLEN read as 0.
- Non-load write data is i_rd_data unmodified.

Test Plan:
- Back-to-back ALU ops: accept rd=5, data=0x11, then rd=6, data=0x22 on consecutive cycles. Required: o_rd_wen high on two consecutive cycles with those values; o_ready stays 1; o_commit_cnt goes 0→1→2.
- Late load: LB, addr_lo=3, i_mem_rdata=0x0000_0000_8000_0000 arrives 4 cycles after accept.
  - o_ready=0 for those 4 cycles.
  - One cycle after rvalid: o_rd_wdata=0xFFFF_FFFF_FFFF_FF80.
  - Next cycle: o_ready=1.
- Same-cycle load: LHU, addr_lo=6, rdata=0xBEEF_0000_0000_0000, rvalid on the accept cycle. Required: next cycle o_rd_wdata=0x0000_0000_0000_BEEF.
- x0 write: accept rd=0, wen=1, data=0xDEAD. Required: o_rd_wen=0, o_commit=1, counter increments.
- Flush in WAIT: flush a pending LW, then pulse rvalid. Required: no o_rd_wen, no o_commit, counter unchanged, o_ready=1 after the flush.
- Reset and wrap:
  - CNT_W=4: retire 17 instructions; o_commit_cnt must read 1.
  - Assert i_rst_n=0 while in WAIT: all outputs 0 on the next edge, state IDLE, and a later rvalid produces no write.

Source files
------------

// File: rtl/wbu_pipe.sv
// Write-back stage: retires one instruction per handshake, waits for late load data,
// extracts/extends load bytes and drives the register-file write port plus commit/retire count.
module wbu_pipe #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 32,
   parameter int unsigned OFF_W = $clog2(XLEN/8)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_flush,
   input  logic [XLEN-1:0]  i_rd_data,
   input  logic [4:0]       i_rd_addr,
   input  logic             i_rd_wen,
   input  logic             i_mem_read,
   input  logic [2:0]       i_load_type,
   input  logic [OFF_W-1:0] i_addr_lo,
   input  logic             i_mem_rvalid,
   input  logic [XLEN-1:0]  i_mem_rdata,
   output logic             o_rd_wen,
   output logic [4:0]       o_rd_addr,
   output logic [XLEN-1:0]  o_rd_wdata,
   output logic             o_commit,
   output logic [CNT_W-1:0] o_commit_cnt
);

   localparam int unsigned SH_W = OFF_W + 3;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_retire;
   logic             w_use_load;

   logic [4:0]       r_cap_addr;
   logic             r_cap_wen;
   logic [2:0]       r_cap_type;
   logic [OFF_W-1:0] r_cap_lo;

   logic [4:0]       w_sel_addr;
   logic             w_sel_wen;
   logic [2:0]       w_sel_type;
   logic [OFF_W-1:0] w_sel_lo;
   logic [SH_W-1:0]  w_shamt;
   logic [XLEN-1:0]  w_sh;
   logic [XLEN-1:0]  w_load_data;
   logic [XLEN-1:0]  w_wdata;
   logic             w_wen_nxt;

   assign o_ready  = (r_state == S_IDLE);
   assign w_accept = i_valid && o_ready && !i_flush;

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state and retire decision; in WAIT a flush beats a same-cycle rvalid
   always_comb begin
      w_state_nxt = r_state;
      w_retire    = 1'b0;
      w_use_load  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!i_mem_read) begin
                  w_retire = 1'b1;
               end else if (i_mem_rvalid) begin
                  w_retire   = 1'b1;
                  w_use_load = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (i_flush) begin
               w_state_nxt = S_IDLE;
            end else if (i_mem_rvalid) begin
               w_retire    = 1'b1;
               w_use_load  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cap_addr <= 5'd0;
         r_cap_wen  <= 1'b0;
         r_cap_type <= 3'd0;
         r_cap_lo   <= '0;
      end else if (w_accept) begin
         r_cap_addr <= i_rd_addr;
         r_cap_wen  <= i_rd_wen;
         r_cap_type <= i_load_type;
         r_cap_lo   <= i_addr_lo;
      end
   end

   // Fields come straight from MEM when retiring in IDLE, from the capture in WAIT
   assign w_sel_addr = (r_state == S_WAIT) ? r_cap_addr : i_rd_addr;
   assign w_sel_wen  = (r_state == S_WAIT) ? r_cap_wen  : i_rd_wen;
   assign w_sel_type = (r_state == S_WAIT) ? r_cap_type : i_load_type;
   assign w_sel_lo   = (r_state == S_WAIT) ? r_cap_lo   : i_addr_lo;

   assign w_shamt = {w_sel_lo, 3'b000};
   assign w_sh    = i_mem_rdata >> w_shamt;

   always_comb begin
      w_load_data = w_sh;
      case (w_sel_type)
         3'b000:  w_load_data = XLEN'($signed(w_sh[7:0]));
         3'b001:  w_load_data = XLEN'($signed(w_sh[15:0]));
         3'b010:  w_load_data = XLEN'($signed(w_sh[31:0]));
         3'b100:  w_load_data = XLEN'(w_sh[7:0]);
         3'b101:  w_load_data = XLEN'(w_sh[15:0]);
         3'b110:  w_load_data = XLEN'(w_sh[31:0]);
         default: w_load_data = w_sh;
      endcase
   end

   assign w_wdata   = w_use_load ? w_load_data : i_rd_data;
   assign w_wen_nxt = w_retire && w_sel_wen && (w_sel_addr != 5'd0);

   // Register-file port and commit outputs; address/data hold between retires
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_rd_wen     <= 1'b0;
         o_rd_addr    <= 5'd0;
         o_rd_wdata   <= '0;
         o_commit     <= 1'b0;
         o_commit_cnt <= '0;
      end else begin
         o_rd_wen <= w_wen_nxt;
         o_commit <= w_retire;
         if (w_retire) begin
            o_rd_addr    <= w_sel_addr;
            o_rd_wdata   <= w_wdata;
            o_commit_cnt <= o_commit_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_wbu_pipe.sv
// Directed bench for wbu_pipe: expected retires are queued at drive time and
// compared when o_commit appears; counter and handshake checked alongside.
module tb_wbu_pipe;

   typedef struct packed {
      logic        wen;
      logic [4:0]  addr;
      logic [63:0] data;
   } exp_t;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic        i_flush;
   logic [63:0] i_rd_data;
   logic [4:0]  i_rd_addr;
   logic        i_rd_wen;
   logic        i_mem_read;
   logic [2:0]  i_load_type;
   logic [2:0]  i_addr_lo;
   logic        i_mem_rvalid;
   logic [63:0] i_mem_rdata;
   logic        o_rd_wen;
   logic [4:0]  o_rd_addr;
   logic [63:0] o_rd_wdata;
   logic        o_commit;
   logic [3:0]  o_commit_cnt;

   exp_t        sb[$];
   logic [3:0]  exp_cnt;
   int          n_cmp = 0;
   int          n_err = 0;

   wbu_pipe #(.XLEN(64), .CNT_W(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_flush(i_flush), .i_rd_data(i_rd_data), .i_rd_addr(i_rd_addr),
      .i_rd_wen(i_rd_wen), .i_mem_read(i_mem_read), .i_load_type(i_load_type),
      .i_addr_lo(i_addr_lo), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
      .o_rd_wen(o_rd_wen), .o_rd_addr(o_rd_addr), .o_rd_wdata(o_rd_wdata),
      .o_commit(o_commit), .o_commit_cnt(o_commit_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic quiet();
      i_valid = 1'b0; i_flush = 1'b0; i_mem_rvalid = 1'b0; i_mem_read = 1'b0;
   endtask

   task automatic offer(input logic ld, input logic [2:0] lt, input logic [2:0] lo,
                        input logic [4:0] rd, input logic wen, input logic [63:0] data,
                        input logic rv, input logic [63:0] rdata);
      i_valid = 1'b1; i_mem_read = ld; i_load_type = lt; i_addr_lo = lo;
      i_rd_addr = rd; i_rd_wen = wen; i_rd_data = data;
      i_mem_rvalid = rv; i_mem_rdata = rdata;
   endtask

   // Advance one cycle and check the retire port against the scoreboard
   task automatic tick();
      exp_t e;
      @(posedge i_clk);
      #1;
      if (o_commit === 1'b1) begin
         if (sb.size() == 0) begin
            chk("commit_unexpected", 64'(o_commit), 64'd0);
         end else begin
            e = sb.pop_front();
            exp_cnt = exp_cnt + 4'd1;
            chk("rd_wen", 64'(o_rd_wen), 64'(e.wen));
            chk("rd_addr", 64'(o_rd_addr), 64'(e.addr));
            chk("rd_wdata", o_rd_wdata, e.data);
         end
      end else begin
         chk("rd_wen_idle", 64'(o_rd_wen), 64'd0);
      end
      chk("commit_cnt", 64'(o_commit_cnt), 64'(exp_cnt));
   endtask

   function automatic exp_t mk(input logic wen, input logic [4:0] rd, input logic [63:0] d);
      exp_t e;
      e.wen = wen && (rd != 5'd0); e.addr = rd; e.data = d;
      return e;
   endfunction

   initial begin
      exp_cnt = 4'd0;
      i_rst_n = 1'b0; i_rd_data = '0; i_rd_addr = '0; i_rd_wen = 1'b0;
      i_load_type = '0; i_addr_lo = '0; i_mem_rdata = '0;
      quiet();
      tick(); tick();
      chk("rst_rd_addr", 64'(o_rd_addr), 64'd0);
      chk("rst_rd_wdata", o_rd_wdata, 64'd0);
      chk("rst_commit", 64'(o_commit), 64'd0);
      chk("rst_ready", 64'(o_ready), 64'd1);
      i_rst_n = 1'b1;

      // Back-to-back ALU ops
      offer(1'b0, 3'd0, 3'd0, 5'd5, 1'b1, 64'h11, 1'b0, 64'd0);
      sb.push_back(mk(1'b1, 5'd5, 64'h11));
      tick();
      chk("b2b_ready", 64'(o_ready), 64'd1);
      chk("b2b_cnt1", 64'(o_commit_cnt), 64'd1);
      offer(1'b0, 3'd0, 3'd0, 5'd6, 1'b1, 64'h22, 1'b0, 64'd0);
      sb.push_back(mk(1'b1, 5'd6, 64'h22));
      tick();
      chk("b2b_cnt2", 64'(o_commit_cnt), 64'd2);
      quiet();

      // Late LB, data arrives 4 cycles after accept
      offer(1'b1, 3'b000, 3'd3, 5'd7, 1'b1, 64'h0, 1'b0, 64'd0);
      sb.push_back(mk(1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80));
      tick();
      quiet();
      for (int i = 0; i < 3; i++) begin
         chk("late_ready_low", 64'(o_ready), 64'd0);
         tick();
      end
      chk("late_ready_low", 64'(o_ready), 64'd0);
      i_mem_rvalid = 1'b1; i_mem_rdata = 64'h0000_0000_8000_0000;
      tick();
      chk("late_commit", 64'(o_commit), 64'd1);
      quiet();
      tick();
      chk("late_ready_back", 64'(o_ready), 64'd1);

      // Same-cycle LHU
      offer(1'b1, 3'b101, 3'd6, 5'd8, 1'b1, 64'h0, 1'b1, 64'hBEEF_0000_0000_0000);
      sb.push_back(mk(1'b1, 5'd8, 64'h0000_0000_0000_BEEF));
      tick();
      chk("lhu_commit", 64'(o_commit), 64'd1);

      // x0 write: commit without register write
      offer(1'b0, 3'd0, 3'd0, 5'd0, 1'b1, 64'hDEAD, 1'b0, 64'd0);
      sb.push_back(mk(1'b1, 5'd0, 64'hDEAD));
      tick();
      chk("x0_commit", 64'(o_commit), 64'd1);
      quiet();

      // Flush of an offered instruction in IDLE
      offer(1'b0, 3'd0, 3'd0, 5'd3, 1'b1, 64'h33, 1'b0, 64'd0);
      i_flush = 1'b1;
      tick();
      quiet();
      tick();

      // Flush a pending LW, then a stray rvalid
      offer(1'b1, 3'b010, 3'd0, 5'd9, 1'b1, 64'h0, 1'b0, 64'd0);
      tick();
      quiet();
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      chk("flush_ready", 64'(o_ready), 64'd1);
      i_mem_rvalid = 1'b1; i_mem_rdata = 64'h1234_5678_9ABC_DEF0;
      tick();
      quiet();

      // Flush and rvalid together in WAIT: flush wins
      offer(1'b1, 3'b011, 3'd0, 5'd11, 1'b1, 64'h0, 1'b0, 64'd0);
      tick();
      quiet();
      i_flush = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 64'hFFFF;
      tick();
      quiet();
      chk("flushrv_ready", 64'(o_ready), 64'd1);
      tick();

      // Reset while waiting on a load
      offer(1'b1, 3'b011, 3'd0, 5'd10, 1'b1, 64'h0, 1'b0, 64'd0);
      tick();
      quiet();
      chk("wait_ready", 64'(o_ready), 64'd0);
      i_rst_n = 1'b0;
      exp_cnt = 4'd0;
      tick();
      chk("rstw_rd_addr", 64'(o_rd_addr), 64'd0);
      chk("rstw_rd_wdata", o_rd_wdata, 64'd0);
      chk("rstw_ready", 64'(o_ready), 64'd1);
      i_rst_n = 1'b1;
      i_mem_rvalid = 1'b1; i_mem_rdata = 64'hAAAA;
      tick();
      quiet();

      // 17 retires wrap a 4-bit counter to 1
      for (int i = 0; i < 17; i++) begin
         offer(1'b0, 3'd0, 3'd0, 5'(i + 1), 1'b1, 64'(i * 3 + 1), 1'b0, 64'd0);
         sb.push_back(mk(1'b1, 5'(i + 1), 64'(i * 3 + 1)));
         tick();
      end
      quiet();
      tick();
      chk("wrap_cnt", 64'(o_commit_cnt), 64'd1);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
